// File: rtl/vga_timing_pkg.sv
// Shared 800x600@72 timing constants and the sync decoder FSM state type.
// The same constants are used by the VGA timing generator.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL  = 1040;
  localparam int VGA_H_SYNC   = 120;
  localparam int VGA_H_BACK   = 64;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_V_TOTAL  = 666;
  localparam int VGA_V_SYNC   = 6;
  localparam int VGA_V_BACK   = 23;
  localparam int VGA_V_ACTIVE = 600;

  localparam int HPOS_W = 11;
  localparam int VPOS_W = 10;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCK    = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises one raw sync input, normalises it to active-high and flags
// the leading edge of each pulse.
module sync_edge_detect #(
  parameter bit POL = 1'b1
) (
  input  logic CLKt,
  input  logic RST,
  input  logic din,
  output logic lvl,
  output logic lead
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic lvl_q, lvl_d;
  logic dly_q, dly_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    lvl_d  = sync_q ^ ~POL;
    dly_d  = lvl_q;
  end

  // Raw flops reset to the idle level so release from reset never looks like an edge.
  always_ff @(posedge CLKt) begin
    if (RST) begin
      meta_q <= ~POL;
      sync_q <= ~POL;
      lvl_q  <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      dly_q  <= dly_d;
    end
  end

  assign lvl  = lvl_q;
  assign lead = lvl_q & ~dly_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from raw HSYNC/VSYNC, measures line/frame length
// and reports lock against the expected video timing.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              CLKt,
  input  logic              RST,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  output logic [HPOS_W-1:0] HPOS,
  output logic [VPOS_W-1:0] VPOS,
  output logic              ACTIVE,
  output logic              LOCKED,
  output logic [HPOS_W-1:0] LINE_LEN,
  output logic [VPOS_W-1:0] FRAME_LINES,
  output logic              ERR
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HPOS_W:0]   H_TOT_W  = (HPOS_W+1)'(H_TOTAL);
  localparam logic [VPOS_W:0]   V_TOT_W  = (VPOS_W+1)'(V_TOTAL);
  localparam logic [HPOS_W-1:0] H_ACT_LO = HPOS_W'(H_SYNC + H_BACK);
  localparam logic [HPOS_W-1:0] H_ACT_HI = HPOS_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VPOS_W-1:0] V_ACT_LO = VPOS_W'(V_SYNC + V_BACK);
  localparam logic [VPOS_W-1:0] V_ACT_HI = VPOS_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [HPOS_W-1:0] HPOS_MAX = '1;
  localparam logic [VPOS_W-1:0] VPOS_MAX = '1;
  localparam logic [GW-1:0]     LOCK_CNT = GW'(LOCK_FRAMES);

  logic h_lead, v_lead, hs_lvl_unused, vs_lvl_unused;

  sync_edge_detect #(.POL(HS_POL)) u_hs_edge (
    .CLKt(CLKt), .RST(RST), .din(HSYNC_IN), .lvl(hs_lvl_unused), .lead(h_lead)
  );
  sync_edge_detect #(.POL(VS_POL)) u_vs_edge (
    .CLKt(CLKt), .RST(RST), .din(VSYNC_IN), .lvl(vs_lvl_unused), .lead(v_lead)
  );

  logic [HPOS_W-1:0] hpos_q, hpos_d, line_len_q, line_len_d;
  logic [VPOS_W-1:0] vpos_q, vpos_d, frame_lines_q, frame_lines_d;
  logic [GW-1:0]     good_cnt_q, good_cnt_d, good_inc;
  state_t            state_q, state_d;
  logic              line_bad_q, line_bad_d, locked_q, locked_d, err_q, err_d;

  // Lengths are one wider than the counters so a saturated count never aliases.
  logic [HPOS_W:0] line_len_next;
  logic [VPOS_W:0] frame_len_next;
  logic            h_bad, v_bad, h_miss, frame_ok;

  always_comb begin
    line_len_next  = {1'b0, hpos_q} + 1'b1;
    frame_len_next = {1'b0, vpos_q} + 1'b1;
    h_bad          = h_lead && (line_len_next != H_TOT_W);
    v_bad          = v_lead && (frame_len_next != V_TOT_W);
    h_miss         = !h_lead && (hpos_q == HPOS_MAX - 1'b1);
    frame_ok       = (frame_len_next == V_TOT_W) && !line_bad_q && !h_bad;
    good_inc       = good_cnt_q + GW'(1);
  end

  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    if (h_lead) begin
      hpos_d     = '0;
      line_len_d = line_len_next[HPOS_W-1:0];
      if (vpos_q != VPOS_MAX) vpos_d = vpos_q + 1'b1;
    end else if (hpos_q != HPOS_MAX) begin
      hpos_d = hpos_q + 1'b1;
    end
    if (v_lead) begin
      vpos_d        = '0;
      frame_lines_d = frame_len_next[VPOS_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    line_bad_d = line_bad_q | h_bad;
    case (state_q)
      SEARCH: begin
        if (v_lead) begin
          state_d    = MEASURE;
          good_cnt_d = '0;
          line_bad_d = 1'b0;
        end
      end
      MEASURE: begin
        if (v_lead) begin
          line_bad_d = 1'b0;
          if (!frame_ok) begin
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_CNT) begin
              state_d  = LOCK;
              locked_d = 1'b1;
            end
          end
        end
      end
      LOCK: begin
        // h_miss fires only on the step into saturation, so a dead HSYNC gives one pulse.
        if (h_bad || v_bad || h_miss) begin
          state_d    = MEASURE;
          err_d      = 1'b1;
          locked_d   = 1'b0;
          good_cnt_d = '0;
          line_bad_d = 1'b0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLKt) begin
    if (RST) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      good_cnt_q    <= '0;
      state_q       <= SEARCH;
      line_bad_q    <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      good_cnt_q    <= good_cnt_d;
      state_q       <= state_d;
      line_bad_q    <= line_bad_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign HPOS        = hpos_q;
  assign VPOS        = vpos_q;
  assign LINE_LEN    = line_len_q;
  assign FRAME_LINES = frame_lines_q;
  assign LOCKED      = locked_q;
  assign ERR         = err_q;
  assign ACTIVE      = locked_q && (hpos_q >= H_ACT_LO) && (hpos_q < H_ACT_HI) &&
                       (vpos_q >= V_ACT_LO) && (vpos_q < V_ACT_HI);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: scaled-down timing, positive- and negative-polarity
// instances driven by the same sync stream and compared against a behavioural model.
module tb_vga_sync_decoder;

  localparam int HT = 40, HS = 4, HB = 3, HA = 30;
  localparam int VT = 12, VS = 2, VB = 2, VA = 7;
  localparam int LF = 2;
  localparam int HMAX = 2047, VMAX = 1023;

  logic CLKt = 1'b0;
  logic RST = 1'b1;
  logic hs = 1'b0, vs = 1'b0, hs_n = 1'b1, vs_n = 1'b1;

  logic [10:0] a_hpos, a_ll, b_hpos, b_ll;
  logic [9:0]  a_vpos, a_fl, b_vpos, b_fl;
  logic        a_act, a_lk, a_err, b_act, b_lk, b_err;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(LF)
  ) dut_pos (
    .CLKt(CLKt), .RST(RST), .HSYNC_IN(hs), .VSYNC_IN(vs),
    .HPOS(a_hpos), .VPOS(a_vpos), .ACTIVE(a_act), .LOCKED(a_lk),
    .LINE_LEN(a_ll), .FRAME_LINES(a_fl), .ERR(a_err)
  );

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LF)
  ) dut_neg (
    .CLKt(CLKt), .RST(RST), .HSYNC_IN(hs_n), .VSYNC_IN(vs_n),
    .HPOS(b_hpos), .VPOS(b_vpos), .ACTIVE(b_act), .LOCKED(b_lk),
    .LINE_LEN(b_ll), .FRAME_LINES(b_fl), .ERR(b_err)
  );

  always #5 CLKt = ~CLKt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pack(input logic [10:0] hp, input logic [9:0] vp,
                                       input logic ac, input logic lk,
                                       input logic [10:0] ll, input logic [9:0] fl,
                                       input logic er);
    return {19'd0, hp, vp, ac, lk, ll, fl, er};
  endfunction

  // Reference model: leads are taken from the sample history (3-edge pipeline),
  // everything else is plain integer bookkeeping of the decoder rules.
  localparam int M_HUNT = 0, M_QUAL = 1, M_LOCKED = 2;
  bit [3:0] m_hh, m_vh;
  int       m_hpos, m_vpos, m_ll, m_fl, m_good, m_mode;
  bit       m_bad, m_err, m_locked, m_act;

  task automatic model_step(input bit h, input bit v, input bit r, output bit hl, output bit vl);
    bit hmis, vmis, hmiss, fok;
    int old_h, old_v;
    hl = 1'b0;
    vl = 1'b0;
    if (r) begin
      m_hh = '0; m_vh = '0;
      m_hpos = 0; m_vpos = 0; m_ll = 0; m_fl = 0; m_good = 0;
      m_mode = M_HUNT; m_bad = 0; m_err = 0; m_locked = 0; m_act = 0;
      return;
    end
    hl = m_hh[2] && !m_hh[3];
    vl = m_vh[2] && !m_vh[3];
    m_hh = {m_hh[2:0], h};
    m_vh = {m_vh[2:0], v};
    old_h = m_hpos;
    old_v = m_vpos;
    hmis  = hl && (old_h + 1 != HT);
    vmis  = vl && (old_v + 1 != VT);
    hmiss = !hl && (old_h == HMAX - 1);
    if (hl) begin
      m_ll   = (old_h + 1) % 2048;
      m_hpos = 0;
      m_vpos = (old_v < VMAX) ? old_v + 1 : VMAX;
    end else begin
      m_hpos = (old_h < HMAX) ? old_h + 1 : HMAX;
    end
    if (vl) begin
      m_fl   = (old_v + 1) % 1024;
      m_vpos = 0;
    end
    m_err = 0;
    case (m_mode)
      M_HUNT: if (vl) begin m_mode = M_QUAL; m_good = 0; m_bad = 0; end
      M_QUAL: begin
        if (vl) begin
          fok    = (old_v + 1 == VT) && !m_bad && !hmis;
          m_good = fok ? m_good + 1 : 0;
          m_bad  = 0;
          if (m_good == LF) begin m_mode = M_LOCKED; m_locked = 1; end
        end else if (hmis) begin
          m_bad = 1;
        end
      end
      default: begin
        if (hmis || vmis || hmiss) begin
          m_err = 1; m_locked = 0; m_good = 0; m_bad = 0; m_mode = M_QUAL;
        end
      end
    endcase
    m_act = m_locked && (m_hpos >= HS + HB) && (m_hpos < HS + HB + HA) &&
            (m_vpos >= VS + VB) && (m_vpos < VS + VB + VA);
  endtask

  int cyc = 0, vr_n = 0, vr3_cyc = 0, err_cnt = 0, act_cnt = 0, lock_rises = 0;
  bit lat_en = 0, probe_en = 0, coin_en = 0, prev_v = 0, prev_lk = 0, lk_at_err = 0;
  logic [10:0] ll_at_err = '0;

  task automatic tick(input bit h, input bit v, input bit r);
    bit hl, vl;
    logic [63:0] exp_v;
    hs = h; vs = v; hs_n = ~h; vs_n = ~v; RST = r;
    @(posedge CLKt);
    cyc++;
    if (r) vr_n = 0;
    else if (v && !prev_v) begin
      vr_n++;
      if (vr_n == 3) vr3_cyc = cyc;
    end
    prev_v = v;
    model_step(h, v, r, hl, vl);
    #1;
    exp_v = pack(11'(m_hpos), 10'(m_vpos), m_act, m_locked, 11'(m_ll), 10'(m_fl), m_err);
    chk("outs_pos", pack(a_hpos, a_vpos, a_act, a_lk, a_ll, a_fl, a_err), exp_v);
    chk("outs_neg", pack(b_hpos, b_vpos, b_act, b_lk, b_ll, b_fl, b_err), exp_v);
    if (r) chk("rst_clear", pack(a_hpos, a_vpos, a_act, a_lk, a_ll, a_fl, a_err), 64'd0);
    if (coin_en && hl && vl) begin
      chk("coin_hpos", 64'(a_hpos), 64'd0);
      chk("coin_vpos", 64'(a_vpos), 64'd0);
      chk("coin_lines", 64'(a_fl), 64'(VT));
    end
    if (a_err) begin
      err_cnt++;
      ll_at_err = a_ll;
      lk_at_err = a_lk;
    end
    if (a_lk && !prev_lk) begin
      lock_rises++;
      if (lat_en) begin
        chk("lock_lat", 64'(cyc - vr3_cyc), 64'd3);
        chk("lock_vsync_n", 64'(vr_n), 64'd3);
        lat_en = 0;
      end
    end
    prev_lk = a_lk;
    if (a_act) begin
      act_cnt++;
      if (probe_en) begin
        chk("first_act_h", 64'(a_hpos), 64'(HS + HB));
        chk("first_act_v", 64'(a_vpos), 64'(VS + VB));
        probe_en = 0;
      end
    end
  endtask

  // One frame; VSYNC starts with HSYNC at the top of line 0. Pulse widths are random.
  task automatic run_frame(input int long_line, input int rst_line, input bit jitter);
    int vsw, len, hw;
    vsw = int'($urandom_range(3, 1));
    for (int ln = 0; ln < VT; ln++) begin
      len = HT;
      hw  = int'($urandom_range(8, 1));
      if (ln == long_line) len = HT + 1;
      if (jitter && $urandom_range(7, 0) == 0) len = HT - 1 + int'($urandom_range(3, 0));
      for (int i = 0; i < len; i++) tick(i < hw, ln < vsw, (ln == rst_line) && (i == 20));
    end
  endtask

  initial begin
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    chk("rst_pos", pack(a_hpos, a_vpos, a_act, a_lk, a_ll, a_fl, a_err), 64'd0);
    chk("rst_neg", pack(b_hpos, b_vpos, b_act, b_lk, b_ll, b_fl, b_err), 64'd0);

    // Ideal stream from reset.
    lat_en = 1;
    run_frame(-1, -1, 1'b0);
    chk("line_len", 64'(a_ll), 64'(HT));
    coin_en = 1;
    run_frame(-1, -1, 1'b0);
    chk("frame_lines", 64'(a_fl), 64'(VT));
    run_frame(-1, -1, 1'b0);
    chk("locked_ideal", 64'(a_lk), 64'd1);
    act_cnt = 0;
    probe_en = 1;
    run_frame(-1, -1, 1'b0);
    chk("act_per_frame", 64'(act_cnt), 64'(HA * VA));
    coin_en = 0;

    // One long line while locked.
    err_cnt = 0;
    run_frame(3, -1, 1'b0);
    chk("err_pulses", 64'(err_cnt), 64'd1);
    chk("err_line_len", 64'(ll_at_err), 64'(HT + 1));
    chk("err_locked", 64'(lk_at_err), 64'd0);
    run_frame(-1, -1, 1'b0);
    run_frame(-1, -1, 1'b0);
    chk("relock_long", 64'(a_lk), 64'd1);
    chk("err_quiet", 64'(err_cnt), 64'd1);

    // HSYNC disappears while locked.
    err_cnt = 0;
    repeat (2100) tick(1'b0, 1'b0, 1'b0);
    chk("miss_hpos", 64'(a_hpos), 64'd2047);
    chk("miss_err", 64'(err_cnt), 64'd1);
    chk("miss_locked", 64'(a_lk), 64'd0);
    chk("miss_active", 64'(a_act), 64'd0);
    repeat (3) run_frame(-1, -1, 1'b0);
    chk("relock_miss", 64'(a_lk), 64'd1);

    // Reset pulse mid-frame while locked; relock must follow the power-up timing.
    lat_en = 1;
    lock_rises = 0;
    run_frame(-1, 5, 1'b0);
    repeat (3) run_frame(-1, -1, 1'b0);
    chk("relock_rst", 64'(a_lk), 64'd1);
    chk("lock_rises", 64'(lock_rises), 64'd1);

    // Random line-length jitter, model-checked every cycle.
    repeat (4) run_frame(-1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
